// File: rtl/cc_line_serializer.sv
// ----------------------------------------------------------------------------
// cc_line_serializer
//
// Converts one 512-bit cache line into an 8-beat AXI R burst of 64-bit words.
// The burst starts at the critical word (line_offset_i) and wraps around the
// line, so beat k carries word (offset + k) mod 8. All R-channel outputs are
// registered, and the first beat appears the cycle after the line is accepted.
//
// Optional feature (compile-time macro CC_LINE_SERIALIZER_DBUF_EN):
//   When defined, a second line buffer is added. A new line can be accepted
//   while a burst is in flight. The queued line then starts immediately after
//   the final beat of the current burst, with no idle cycle between bursts.
//   When undefined, a line is accepted only in the idle state, and there is
//   one idle cycle between consecutive bursts.
//
// Ports
//   clk            in   1    clock, all logic on the rising edge
//   rst            in   1    synchronous reset, active-high
//   line_valid_i   in   1    cache line offered
//   line_ready_o   out  1    line accepted this cycle when line_valid_i is high
//   line_data_i    in   512  line data, word w = bits [64w+63:64w]
//   line_offset_i  in   3    critical-word index
//   line_id_i      in   4    transaction ID, echoed on every beat
//   inct_rdata_o   out  64   R data beat
//   inct_rid_o     out  4    R ID
//   inct_rresp_o   out  2    R response, always OKAY
//   inct_rlast_o   out  1    final beat of the burst
//   inct_rvalid_o  out  1    beat valid
//   inct_rready_i  in   1    downstream accepts the beat
// ----------------------------------------------------------------------------
module cc_line_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_valid_i,
  output logic         line_ready_o,
  input  logic [511:0] line_data_i,
  input  logic [2:0]   line_offset_i,
  input  logic [3:0]   line_id_i,
  output logic [63:0]  inct_rdata_o,
  output logic [3:0]   inct_rid_o,
  output logic [1:0]   inct_rresp_o,
  output logic         inct_rlast_o,
  output logic         inct_rvalid_o,
  input  logic         inct_rready_i
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e       r_state;

  // Buffer holding the line whose burst is currently being sent.
  logic [511:0] r_buf_data;
  logic [2:0]   r_buf_off;
  logic [3:0]   r_buf_id;

  // Index of the beat currently presented on the R channel.
  logic [2:0]   r_cnt;

  logic         r_rvalid;
  logic         r_rlast;
  logic [63:0]  r_rdata;
  logic [3:0]   r_rid;

  logic         w_accept;
  logic         w_hs;
  logic         w_last_hs;
  logic         w_start;
  logic [511:0] w_src_data;
  logic [2:0]   w_src_off;
  logic [3:0]   w_src_id;
  logic [2:0]   w_next_idx;

  function automatic logic [63:0] f_word(input logic [511:0] d, input logic [2:0] idx);
    return d[{idx, 6'd0} +: 64];
  endfunction

  assign w_accept  = line_valid_i && line_ready_o;
  assign w_hs      = r_rvalid && inct_rready_i;
  assign w_last_hs = w_hs && (r_cnt == 3'd7);

  // The 3-bit sum wraps naturally, which gives the wrap-around word order.
  assign w_next_idx = r_buf_off + r_cnt + 3'd1;

`ifdef CC_LINE_SERIALIZER_DBUF_EN
  // Second buffer: a line queued behind the active burst.
  logic         r_pend_valid;
  logic [511:0] r_pend_data;
  logic [2:0]   r_pend_off;
  logic [3:0]   r_pend_id;

  // Ready depends only on state and reset, never on line_valid_i.
  assign line_ready_o = !rst && !r_pend_valid;

  // A burst starts from idle on accept. It also starts back-to-back when the
  // final beat is handshaken and either a queued line exists or a new line
  // arrives in the same cycle.
  assign w_start = (r_state == StIdle) ? w_accept
                                       : (w_last_hs && (w_accept || r_pend_valid));

  // The queued line, if any, is older than anything on the inputs.
  assign w_src_data = r_pend_valid ? r_pend_data : line_data_i;
  assign w_src_off  = r_pend_valid ? r_pend_off  : line_offset_i;
  assign w_src_id   = r_pend_valid ? r_pend_id   : line_id_i;
`else
  assign line_ready_o = !rst && (r_state == StIdle);
  assign w_start      = w_accept;
  assign w_src_data   = line_data_i;
  assign w_src_off    = line_offset_i;
  assign w_src_id     = line_id_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_buf_data <= '0;
      r_buf_off  <= 3'd0;
      r_buf_id   <= 4'd0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdata    <= 64'd0;
      r_rid      <= 4'd0;
`ifdef CC_LINE_SERIALIZER_DBUF_EN
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_off   <= 3'd0;
      r_pend_id    <= 4'd0;
`endif
    end else begin
      if (w_start) begin
        // Load a new burst. Beat 0 is the critical word.
        r_state    <= StSend;
        r_buf_data <= w_src_data;
        r_buf_off  <= w_src_off;
        r_buf_id   <= w_src_id;
        r_cnt      <= 3'd0;
        r_rvalid   <= 1'b1;
        r_rlast    <= 1'b0;
        r_rdata    <= f_word(w_src_data, w_src_off);
        r_rid      <= w_src_id;
      end else if (w_hs) begin
        if (r_cnt == 3'd7) begin
          r_state  <= StIdle;
          r_cnt    <= 3'd0;
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
        end else begin
          r_cnt   <= r_cnt + 3'd1;
          r_rdata <= f_word(r_buf_data, w_next_idx);
          r_rlast <= (r_cnt == 3'd6);
        end
      end
      // Without a handshake the beat registers simply hold (stall).

`ifdef CC_LINE_SERIALIZER_DBUF_EN
      if (w_accept && (r_state == StSend) && !w_last_hs) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= line_data_i;
        r_pend_off   <= line_offset_i;
        r_pend_id    <= line_id_i;
      end else if (w_start && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end
`endif
    end
  end

  assign inct_rdata_o  = r_rdata;
  assign inct_rid_o    = r_rid;
  assign inct_rresp_o  = 2'b00;
  assign inct_rlast_o  = r_rlast;
  assign inct_rvalid_o = r_rvalid;

endmodule

// File: tb/tb_cc_line_serializer.sv
// ----------------------------------------------------------------------------
// Testbench for cc_line_serializer.
//
// A reference model holds a queue of the beats still owed. Every accepted line
// adds its 8 beats in wrap order, and every R handshake pops one beat. The
// bench compares outputs against this queue on every cycle. Directed table
// vectors, a reset-mid-burst sequence, a back-to-back sequence and a
// randomized run use this model.
// ----------------------------------------------------------------------------
module tb_cc_line_serializer;

`ifdef CC_LINE_SERIALIZER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  // Number of owed beats at which the serializer can still take a new line.
  localparam int READY_LIMIT = DBUF ? 8 : 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid;
  logic         line_ready;
  logic [511:0] line_data;
  logic [2:0]   line_offset;
  logic [3:0]   line_id;
  logic [63:0]  rdata;
  logic [3:0]   rid;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  always #5 clk = ~clk;

  cc_line_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .line_valid_i (line_valid),
    .line_ready_o (line_ready),
    .line_data_i  (line_data),
    .line_offset_i(line_offset),
    .line_id_i    (line_id),
    .inct_rdata_o (rdata),
    .inct_rid_o   (rid),
    .inct_rresp_o (rresp),
    .inct_rlast_o (rlast),
    .inct_rvalid_o(rvalid),
    .inct_rready_i(rready)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [2:0]       off;
    logic [3:0]       id;
    logic [63:0]      base;   // word w of the line = base + w
    logic             stall;  // rready pattern 1,0,0,1,0,0,...
    logic [0:7][63:0] exp;    // expected rdata for beats 0..7
  } vec_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  bit    m_init   = 1'b0;
  int    cyc      = 0;

  logic        s_ready, s_valid, s_last;
  logic [63:0] s_data;
  logic [3:0]  s_id;
  logic [1:0]  s_resp;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock cycle: sample and check at the negedge, update the model at
  // the posedge, and return 1 time unit later so the caller can drive inputs.
  task automatic step();
    bit           acc, ohs, r;
    logic [511:0] d;
    logic [2:0]   o;
    logic [3:0]   id;
    beat_t        b;
    @(negedge clk);
    s_ready = line_ready;
    s_valid = rvalid;
    s_data  = rdata;
    s_id    = rid;
    s_last  = rlast;
    s_resp  = rresp;
    if (m_init) begin
      chk("ready", s_ready, !rst && (q.size() <= READY_LIMIT));
      chk("rvalid", s_valid, q.size() != 0);
      if (s_valid && q.size() != 0) begin
        chk("rdata", s_data, q[0].data);
        chk("rid", s_id, q[0].id);
        chk("rlast", s_last, q[0].last);
      end
    end
    acc = line_valid && s_ready;
    ohs = s_valid && rready;
    r   = rst;
    d   = line_data;
    o   = line_offset;
    id  = line_id;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      m_init = 1'b1;
    end else begin
      if (ohs && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        for (int k = 0; k < 8; k++) begin
          b.data = d[((int'(o) + k) % 8) * 64 +: 64];
          b.id   = id;
          b.last = (k == 7);
          q.push_back(b);
        end
      end
    end
    #1;
  endtask

  task automatic set_line(input logic [63:0] base, input logic [2:0] off, input logic [3:0] id);
    for (int w = 0; w < 8; w++) line_data[w*64 +: 64] = base + 64'(w);
    line_offset = off;
    line_id     = id;
  endtask

  task automatic run_vec(input vec_t v);
    bit acc;
    int k, n;
    set_line(v.base, v.off, v.id);
    line_valid = 1'b1;
    rready     = 1'b1;
    acc        = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      step();
      acc = s_ready;
    end
    line_valid = 1'b0;
    chk("vec_accept", 64'(acc), 64'd1);
    k = 0;
    n = 0;
    while (k < 8 && n < 100) begin
      rready = v.stall ? (n % 3 == 0) : 1'b1;
      step();
      if (n == 0) chk("vec_first_beat_latency", 64'(s_valid), 64'd1);
      if (s_valid && rready) begin
        chk("vec_rdata", s_data, v.exp[k]);
        chk("vec_rlast", 64'(s_last), 64'(k == 7));
        chk("vec_rid", 64'(s_id), 64'(v.id));
        chk("vec_rresp", 64'(s_resp), 64'd0);
        k++;
      end
      n++;
    end
    chk("vec_beats", 64'(k), 64'd8);
    chk("vec_cycles", 64'(n), v.stall ? 64'd22 : 64'd8);
    rready = 1'b1;
    step();
    chk("vec_idle_rvalid", 64'(s_valid), 64'd0);
    chk("vec_idle_ready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   hs, nacc, nb, first, last;
    logic [3:0] first_id, last_id;

    vecs[0] = '{3'd0, 4'h3, 64'h0, 1'b0,
                {64'h0, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7}};
    vecs[1] = '{3'd5, 4'hA, 64'hA0, 1'b0,
                {64'hA5, 64'hA6, 64'hA7, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4}};
    vecs[2] = '{3'd2, 4'h6, 64'h100, 1'b1,
                {64'h102, 64'h103, 64'h104, 64'h105, 64'h106, 64'h107, 64'h100, 64'h101}};
    vecs[3] = '{3'd7, 4'hF, 64'h700, 1'b0,
                {64'h707, 64'h700, 64'h701, 64'h702, 64'h703, 64'h704, 64'h705, 64'h706}};

    // Reset: ready low during reset, then clean outputs and ready high.
    rst        = 1'b1;
    line_valid = 1'b0;
    rready     = 1'b0;
    set_line(64'h0, 3'd0, 4'd0);
    step();
    step();
    chk("reset_ready_low", 64'(s_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("post_reset_ready", 64'(s_ready), 64'd1);
    chk("post_reset_rvalid", 64'(s_valid), 64'd0);
    chk("post_reset_rdata", s_data, 64'd0);
    chk("post_reset_rid", 64'(s_id), 64'd0);
    chk("post_reset_rlast", 64'(s_last), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset after the third handshake of a burst abandons that burst.
    set_line(64'h900, 3'd1, 4'h9);
    line_valid = 1'b1;
    rready     = 1'b1;
    hs         = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      step();
      if (line_valid && s_ready) line_valid = 1'b0;
      else if (s_valid && rready) hs++;
    end
    chk("mid_reset_handshakes", 64'(hs), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_reset_rvalid", 64'(s_valid), 64'd0);
    chk("mid_reset_ready", 64'(s_ready), 64'd1);
    run_vec(vecs[0]);

    // Two lines offered back-to-back, with the source holding valid until accept.
    set_line(64'h1000, 3'd0, 4'h1);
    line_valid = 1'b1;
    rready     = 1'b1;
    nacc = 0; nb = 0; first = 0; last = 0; first_id = 4'd0; last_id = 4'd0;
    for (int i = 0; i < 100 && nb < 16; i++) begin
      step();
      if (line_valid && s_ready) begin
        nacc++;
        if (nacc == 1) set_line(64'h2000, 3'd3, 4'h2);
        else line_valid = 1'b0;
      end
      if (s_valid) begin
        if (nb == 0) begin
          first    = cyc;
          first_id = s_id;
        end
        last    = cyc;
        last_id = s_id;
        nb++;
      end
    end
    line_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("b2b_accepts", 64'(nacc), 64'd2);
    chk("b2b_beats", 64'(nb), 64'd16);
    chk("b2b_span", 64'(last - first + 1), DBUF ? 64'd16 : 64'd17);
    chk("b2b_first_id", 64'(first_id), 64'h1);
    chk("b2b_last_id", 64'(last_id), 64'h2);

    // Randomized traffic with random backpressure and occasional reset.
    line_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!line_valid && $urandom_range(0, 1) == 1) begin
        for (int w = 0; w < 8; w++) line_data[w*64 +: 64] = {$urandom, $urandom};
        line_offset = 3'($urandom_range(0, 7));
        line_id     = 4'($urandom_range(0, 15));
        line_valid  = 1'b1;
      end
      rready = ($urandom_range(0, 9) < 7);
      rst    = ($urandom_range(0, 199) == 0);
      step();
      if (line_valid && s_ready) line_valid = 1'b0;
    end
    rst        = 1'b0;
    line_valid = 1'b0;
    rready     = 1'b1;
    for (int i = 0; i < 24; i++) step();
    chk("random_drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
